// File: rtl/waveform_pkg.sv
`default_nettype none
// ============================================================================
// Module      : waveform_pkg
// Description : Shared types and pointer helpers for the waveform capture
//               engine (FSM state encoding, 16-bit counter type, ring-buffer
//               modulo add).
// Revision    : 1.0 - initial release
// ============================================================================
package waveform_pkg;

  // Capture engine states
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    READY = 2'd3
  } wave_state_t;

  // Status counters exported to the readout logic
  typedef logic [15:0] count16_t;

  localparam count16_t c_cnt_max = 16'hFFFF;

  // (a + b) mod depth for a < depth, b <= depth: one conditional subtract,
  // no divider. Callers truncate the result to their pointer width.
  function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] depth);
    logic [31:0] sum;
    sum = a + b;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wave_ring_ram.sv
`default_nettype none
// ============================================================================
// Module      : wave_ring_ram
// Description : Simple dual-port ring memory, DEPTH x WIDTH, one write port
//               and one registered read port so it maps onto block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_ring_ram #(
  parameter int DEPTH  = 500,
  parameter int WIDTH  = 28,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port and registered read port; contents are never reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/waveform_capture_mc.sv
`default_nettype none
// ============================================================================
// Module      : waveform_capture_mc
// Description : Multi-channel pre/post-trigger waveform capture. Samples are
//               written continuously into a ring buffer; a trigger edge
//               freezes a DEPTH-sample window that is read out by address
//               and released with rd_done.
//               Optional build macro WAVEFORM_TIMESTAMP_EN adds trig_time,
//               the free-running cycle count latched at the trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module waveform_capture_mc
  import waveform_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 14,
  parameter int DEPTH    = 500,
  parameter int PRE      = 50,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     trig_in,
  input  logic [N_CH*SAMPLE_W-1:0] signal,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [N_CH*SAMPLE_W-1:0] rd_data,
  input  logic                     rd_done,
  output logic                     ready,
  output logic                     busy,
  output logic [15:0]              wave_number,
  output logic [15:0]              missed_trig
`ifdef WAVEFORM_TIMESTAMP_EN
  ,
  output logic [31:0]              trig_time
`endif
);

  localparam int              c_data_w    = N_CH * SAMPLE_W;
  localparam logic [ADDR_W:0] c_pre_cnt   = (ADDR_W+1)'(PRE);
  localparam logic [ADDR_W:0] c_post_len  = (ADDR_W+1)'(DEPTH - PRE - 1);
  localparam logic [ADDR_W:0] c_post_last = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_depth     = (ADDR_W+1)'(DEPTH);

  wave_state_t         r_state;
  wave_state_t         w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_start_ptr;
  logic [ADDR_W:0]     r_fill_cnt;
  logic [ADDR_W:0]     r_post_cnt;
  logic                r_trig_q;
  logic                r_rd_zero;
  logic                w_trig_edge;
  logic                w_we;
  logic                w_capture;
  logic                w_rd_oob;
  logic [ADDR_W:0]     w_fill_inc;
  logic [ADDR_W-1:0]   w_wr_ptr_inc;
  logic [ADDR_W-1:0]   w_start_calc;
  logic [ADDR_W-1:0]   w_rd_idx;
  logic [c_data_w-1:0] w_ram_q;

  assign w_trig_edge  = trig_in & ~r_trig_q;
  assign w_fill_inc   = r_fill_cnt + 1'b1;
  assign w_wr_ptr_inc = ADDR_W'(wrap_add(32'(r_wr_ptr), 32'd1, 32'(DEPTH)));
  // Subtracting PRE is done as adding DEPTH-PRE so the helper stays an adder
  assign w_start_calc = ADDR_W'(wrap_add(32'(r_wr_ptr), 32'(DEPTH - PRE), 32'(DEPTH)));
  assign w_rd_oob     = {1'b0, rd_addr} >= c_depth;
  assign w_rd_idx     = w_rd_oob ? '0
                      : ADDR_W'(wrap_add(32'(r_start_ptr), 32'(rd_addr), 32'(DEPTH)));

  assign ready = (r_state == READY);
  assign busy  = (r_state == ARMED) || (r_state == POST);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, write enable and capture strobe; enable low aborts to FILL
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      FILL: begin
        if (enable) begin
          w_we = 1'b1;
          if (w_fill_inc >= c_pre_cnt) begin
            w_state_nxt = ARMED;
          end
        end
      end
      ARMED: begin
        if (!enable) begin
          w_state_nxt = FILL;
        end else begin
          w_we = 1'b1;
          if (w_trig_edge) begin
            w_capture   = 1'b1;
            w_state_nxt = (c_post_len == '0) ? READY : POST;
          end
        end
      end
      POST: begin
        if (!enable) begin
          w_state_nxt = FILL;
        end else begin
          w_we = 1'b1;
          if (r_post_cnt == c_post_last) begin
            w_state_nxt = READY;
          end
        end
      end
      READY: begin
        if (rd_done) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Write pointer, pre-fill count, window start and post-trigger countdown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_start_ptr <= '0;
      r_post_cnt  <= '0;
      r_trig_q    <= 1'b0;
    end else begin
      r_trig_q <= trig_in;
      if (w_we) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      // Only counts while filling; any other state leaves it cleared for re-entry
      r_fill_cnt <= (r_state == FILL && enable) ? w_fill_inc : '0;
      if (w_capture) begin
        r_start_ptr <= w_start_calc;
        r_post_cnt  <= c_post_len;
      end else if (r_state == POST && w_we) begin
        r_post_cnt <= r_post_cnt - 1'b1;
      end
    end
  end

  // Completed-waveform and missed-trigger counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wave_number <= '0;
      missed_trig <= '0;
    end else begin
      if (w_state_nxt == READY && r_state != READY) begin
        wave_number <= wave_number + 16'd1;
      end
      if (w_trig_edge && (r_state == POST || r_state == READY) && missed_trig != c_cnt_max) begin
        missed_trig <= missed_trig + 16'd1;
      end
    end
  end

  // Out-of-range read flag, aligned with the registered RAM output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_zero <= 1'b1;
    end else begin
      r_rd_zero <= w_rd_oob;
    end
  end

  assign rd_data = r_rd_zero ? '0 : w_ram_q;

  wave_ring_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (c_data_w),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (signal),
    .i_raddr (w_rd_idx),
    .o_rdata (w_ram_q)
  );

`ifdef WAVEFORM_TIMESTAMP_EN
  logic [31:0] r_cycle;

  // Free-running cycle counter, sampled into trig_time on the capture edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle   <= '0;
      trig_time <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_capture) begin
        trig_time <= r_cycle;
      end
    end
  end
`endif

endmodule
`default_nettype wire
